ysyx_25040111_memarb: RTL and testbench
=======================================

YSYX_25040111_MEMARB -- requirements
Module: ysyx_25040111_memarb

Interface
REQ-001 Parameter LEN_W, default 8, width of beat-count fields c_len/m_len.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c_valid  input  1  I-cache refill request, held until the final beat is returned.
REQ-005 c_addr  input  32  I-cache refill start address, word-aligned.
REQ-006 c_len  input  LEN_W  I-cache beats minus one.
REQ-007 c_burst  input  1  I-cache burst-mode flag.
REQ-008 c_ready  output  1  one I-cache beat returned this cycle.
REQ-009 c_data  output  32  I-cache beat data, valid when c_ready=1.
REQ-010 l_valid  input  1  LSU single-beat request, held until l_ready.
REQ-011 l_wen  input  1  LSU write enable (1=write, 0=read).
REQ-012 l_addr  input  32  LSU address.
REQ-013 l_wdata  input  32  LSU write data.
REQ-014 l_wmask  input  4  LSU byte strobes.
REQ-015 l_ready  output  1  LSU access complete this cycle.
REQ-016 l_rdata  output  32  LSU read data, valid when l_ready=1 and l_wen=0.
REQ-017 m_valid  output  1  memory request active.
REQ-018 m_wen, m_addr[32], m_len[LEN_W], m_burst, m_wdata[32], m_wmask[4]  output  memory request fields, stable while m_valid=1.
REQ-019 m_ready  input  1  memory returned/accepted one beat this cycle.
REQ-020 m_rdata  input  32  memory beat data, valid when m_ready=1.

Function
REQ-021 States: IDLE, GNT_C, GNT_L; exactly one state active.
REQ-022 IDLE with exactly one of c_valid/l_valid: next state grants that requester.
REQ-023 IDLE with both valid: grant the requester not granted last (last_gnt register); tie-break round-robin.
REQ-024 On grant, latch the granted requester's addr/len/burst/wen/wdata/wmask into m_* registers; LSU grant forces m_len=0, m_burst=0; cache grant forces m_wen=0, m_wmask=0.
REQ-025 m_valid=1 in the first GNT cycle and stays 1 until the cycle the final beat's m_ready is seen, then deasserts next cycle.
REQ-026 Beat counter reset to 0 on grant, incremented on each m_ready while granted; final beat = (count==m_len) & m_ready.
REQ-027 Non-burst cache refill (m_burst=0): m_addr increments by 4 after each m_ready; burst: m_addr held.
REQ-028 Response routing is combinational: c_ready = m_ready & GNT_C; l_ready = m_ready & GNT_L; c_data = l_rdata = m_rdata.
REQ-029 Non-granted requester sees ready=0 in all states; m_ready in IDLE is ignored.
REQ-030 Final beat: next state IDLE, last_gnt updated to the finished requester; minimum one IDLE cycle between grants.
REQ-031 Requester dropping valid mid-grant does not end the grant; arbiter waits for the remaining beats.
REQ-032 Request latency: valid in cycle N (IDLE) -> m_valid=1 in cycle N+1.
REQ-033 Counter width LEN_W+1; no wrap within a transaction for c_len up to 2^LEN_W-1.

Reset
REQ-034 reset: state IDLE, m_valid=0, all m_* fields 0, beat counter 0, last_gnt=LSU (cache wins first tie).
REQ-035 reset mid-transaction aborts immediately; c_ready/l_ready 0 from the reset cycle onward.

Structure
REQ-036 State encoding and the LEN_W default live in the shared ysyx_25040111 header package.
REQ-037 Single module; no sub-modules; arbitration logic is not split out.

Verification
REQ-038 Cache only: c_addr=0x3000_0000, c_len=3, c_burst=0 -> m_addr 0x..00,04,08,0C on successive beats; 4 c_ready pulses; IDLE after beat 4.
REQ-039 LSU write only: l_addr=0x8000_0010, l_wdata=0xDEADBEEF, l_wmask=0xF -> m_wen=1, m_len=0, one l_ready, c_ready never 1.
REQ-040 Simultaneous c_valid/l_valid right after reset -> cache granted first; held l_valid granted next after one IDLE cycle.
REQ-041 Simultaneous requests repeated 4 times -> grants alternate C,L,C,L.
REQ-042 Burst: c_addr=0xA000_0000, c_burst=1, c_len=3 -> m_addr constant, 4 beats delivered, m_rdata routed to c_data each beat.
REQ-043 reset asserted during beat 2 of a 4-beat refill -> m_valid=0 and state IDLE next cycle; fresh l_valid afterwards completes normally.

Source files
------------

// File: rtl/ysyx_25040111_memarb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_memarb_pkg
// Shared definitions for the I-cache / LSU memory arbiter:
//   - LEN_W_DEFAULT : default width of the beat-count fields (beats minus one)
//   - arb_state_t   : arbiter state encoding (IDLE, GNT_C, GNT_L)
//   - owner_t       : identifies which requester finished the last grant
//   - pick_grant    : round-robin grant decision taken from IDLE
// ---------------------------------------------------------------------------
package ysyx_25040111_memarb_pkg;

  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_L = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_C = 1'b0,
    OWNER_L = 1'b1
  } owner_t;

  // A lone requester always wins; on a tie the side that was not served
  // last goes first, so neither requester can starve the other.
  function automatic arb_state_t pick_grant(input logic   c_req,
                                            input logic   l_req,
                                            input owner_t last_gnt);
    arb_state_t result;
    result = IDLE;
    if (c_req && l_req) begin
      result = (last_gnt == OWNER_C) ? GNT_L : GNT_C;
    end else if (c_req) begin
      result = GNT_C;
    end else if (l_req) begin
      result = GNT_L;
    end
    return result;
  endfunction

endpackage

// File: rtl/ysyx_25040111_memarb_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_memarb_if
// Memory-side request/response bus of the arbiter.
//   m_valid                  request active
//   m_wen/m_addr/m_len/
//   m_burst/m_wdata/m_wmask  request fields, stable while m_valid=1
//   m_ready                  one beat returned/accepted this cycle
//   m_rdata                  beat data, valid with m_ready
// Modports:
//   master - the arbiter (drives the request, receives ready/data)
//   slave  - the memory  (receives the request, drives ready/data)
// ---------------------------------------------------------------------------
interface ysyx_25040111_memarb_if
  #(parameter int LEN_W = ysyx_25040111_memarb_pkg::LEN_W_DEFAULT);

  logic             m_valid;
  logic             m_wen;
  logic [31:0]      m_addr;
  logic [LEN_W-1:0] m_len;
  logic             m_burst;
  logic [31:0]      m_wdata;
  logic [3:0]       m_wmask;
  logic             m_ready;
  logic [31:0]      m_rdata;

  modport master (
    output m_valid, m_wen, m_addr, m_len, m_burst, m_wdata, m_wmask,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_valid, m_wen, m_addr, m_len, m_burst, m_wdata, m_wmask,
    output m_ready, m_rdata
  );

endinterface

// File: rtl/ysyx_25040111_memarb.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_memarb
// Arbitrates one memory port between the I-cache refill path and the LSU.
// Round-robin on simultaneous requests, one grant at a time, at least one
// IDLE cycle between grants. Responses are routed combinationally.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   c_valid/c_addr/c_len/
//   c_burst                I-cache refill request (c_len = beats - 1)
//   c_ready/c_data         I-cache beat return
//   l_valid/l_wen/l_addr/
//   l_wdata/l_wmask        LSU single-beat request
//   l_ready/l_rdata        LSU completion / read data
//   mem                    memory bus (master side)
// ---------------------------------------------------------------------------
module ysyx_25040111_memarb
  import ysyx_25040111_memarb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,

  input  logic                        c_valid,
  input  logic [31:0]                 c_addr,
  input  logic [LEN_W-1:0]            c_len,
  input  logic                        c_burst,
  output logic                        c_ready,
  output logic [31:0]                 c_data,

  input  logic                        l_valid,
  input  logic                        l_wen,
  input  logic [31:0]                 l_addr,
  input  logic [31:0]                 l_wdata,
  input  logic [3:0]                  l_wmask,
  output logic                        l_ready,
  output logic [31:0]                 l_rdata,

  ysyx_25040111_memarb_if.master      mem
);

  arb_state_t       state;
  arb_state_t       state_next;
  owner_t           last_gnt;

  // One bit wider than the length so a full 2^LEN_W-beat refill never wraps.
  logic [LEN_W:0]   beat_cnt;

  logic             wen_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic             burst_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;

  logic             beat;
  logic             final_beat;

  // m_ready only counts while a grant is active; in IDLE it is ignored.
  assign beat       = mem.m_ready && (state != IDLE);
  assign final_beat = beat && (beat_cnt == {1'b0, len_q});

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         state_next = pick_grant(c_valid, l_valid, last_gnt);
      GNT_C, GNT_L: if (final_beat) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are captured at grant time so the requester may drop or
  // change its inputs mid-grant without disturbing the memory request.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= OWNER_L;
      beat_cnt <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
      case (state_next)
        GNT_C: begin
          wen_q   <= 1'b0;
          addr_q  <= c_addr;
          len_q   <= c_len;
          burst_q <= c_burst;
          wdata_q <= '0;
          wmask_q <= 4'b0000;
        end
        GNT_L: begin
          wen_q   <= l_wen;
          addr_q  <= l_addr;
          len_q   <= '0;
          burst_q <= 1'b0;
          wdata_q <= l_wdata;
          wmask_q <= l_wmask;
        end
        default: ;
      endcase
    end else if (beat) begin
      beat_cnt <= beat_cnt + (LEN_W+1)'(1);
      // Non-burst refills walk word by word; burst refills keep the start
      // address and let the memory sequence the beats itself.
      if (state == GNT_C && !burst_q) begin
        addr_q <= addr_q + 32'd4;
      end
      if (final_beat) begin
        last_gnt <= (state == GNT_C) ? OWNER_C : OWNER_L;
      end
    end
  end

  assign mem.m_valid = (state != IDLE);
  assign mem.m_wen   = wen_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_len   = len_q;
  assign mem.m_burst = burst_q;
  assign mem.m_wdata = wdata_q;
  assign mem.m_wmask = wmask_q;

  // Gating with reset drops ready in the very cycle an abort is requested.
  assign c_ready = mem.m_ready && (state == GNT_C) && !reset;
  assign l_ready = mem.m_ready && (state == GNT_L) && !reset;
  assign c_data  = mem.m_rdata;
  assign l_rdata = mem.m_rdata;

endmodule

// File: tb/tb_ysyx_25040111_memarb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040111_memarb
// Self-checking bench for the I-cache / LSU memory arbiter: a cycle table
// for single-requester traffic, then hand-written sequences for round-robin
// ties, burst refills with a dropped valid, and reset mid-refill.
// ---------------------------------------------------------------------------
module tb_ysyx_25040111_memarb;
  import ysyx_25040111_memarb_pkg::*;

  localparam int LEN_W = 8;

  localparam logic [31:0] CA  = 32'h3000_0000;
  localparam logic [31:0] LA  = 32'h8000_0010;
  localparam logic [31:0] LR  = 32'h8000_0020;
  localparam logic [31:0] CA2 = 32'h3000_0200;
  localparam logic [31:0] LA2 = 32'h8000_0100;
  localparam logic [31:0] BA  = 32'hA000_0000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             c_valid = 1'b0;
  logic [31:0]      c_addr = '0;
  logic [LEN_W-1:0] c_len = '0;
  logic             c_burst = 1'b0;
  logic             c_ready;
  logic [31:0]      c_data;
  logic             l_valid = 1'b0;
  logic             l_wen = 1'b0;
  logic [31:0]      l_addr = '0;
  logic [31:0]      l_wdata = '0;
  logic [3:0]       l_wmask = '0;
  logic             l_ready;
  logic [31:0]      l_rdata;

  ysyx_25040111_memarb_if #(.LEN_W(LEN_W)) mem_bus ();

  ysyx_25040111_memarb #(.LEN_W(LEN_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .c_valid (c_valid),
    .c_addr  (c_addr),
    .c_len   (c_len),
    .c_burst (c_burst),
    .c_ready (c_ready),
    .c_data  (c_data),
    .l_valid (l_valid),
    .l_wen   (l_wen),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_wmask (l_wmask),
    .l_ready (l_ready),
    .l_rdata (l_rdata),
    .mem     (mem_bus.master)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        cv;
    logic        lv;
    logic        lw;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic        mr;
    logic [31:0] rdata;
    logic        e_crdy;
    logic        e_lrdy;
    logic        e_mv;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic        e_wen;
    logic [3:0]  e_wmask;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic cv, input logic lv, input logic lw,
                              input logic [31:0] laddr, input logic [31:0] lwdata,
                              input logic mr, input logic [31:0] rdata,
                              input logic ec, input logic el, input logic emv,
                              input logic [31:0] eaddr, input logic [7:0] elen,
                              input logic ewen, input logic [3:0] ewm);
    vec_t v;
    v.cv = cv; v.lv = lv; v.lw = lw; v.laddr = laddr; v.lwdata = lwdata;
    v.mr = mr; v.rdata = rdata; v.e_crdy = ec; v.e_lrdy = el; v.e_mv = emv;
    v.e_addr = eaddr; v.e_len = elen; v.e_wen = ewen; v.e_wmask = ewm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Table rows always refill CA with 4 non-burst beats and use a full mask.
  task automatic applyStimulus(input vec_t v);
    c_valid         = v.cv;
    c_addr          = CA;
    c_len           = 8'd3;
    c_burst         = 1'b0;
    l_valid         = v.lv;
    l_wen           = v.lw;
    l_addr          = v.laddr;
    l_wdata         = v.lwdata;
    l_wmask         = 4'hF;
    mem_bus.m_ready = v.mr;
    mem_bus.m_rdata = v.rdata;
  endtask

  task automatic doReset();
    reset           = 1'b1;
    c_valid         = 1'b0;
    l_valid         = 1'b0;
    mem_bus.m_ready = 1'b0;
    mem_bus.m_rdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic waitGrant(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      got = mem_bus.m_valid;
    end
    checkOutput({tag, " grant"}, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants, idle_between, crdy_cnt, lrdy_cnt;
    logic prev_mv;

    vecs[0]  = mk(1,0,0,'0,'0,          0,'0,           0,0,0,'0,      0,0,4'h0);
    vecs[1]  = mk(1,0,0,'0,'0,          1,32'h1111_1111,1,0,1,CA,      3,0,4'h0);
    vecs[2]  = mk(1,0,0,'0,'0,          0,'0,           0,0,1,CA+4,    3,0,4'h0);
    vecs[3]  = mk(1,0,0,'0,'0,          1,32'h2222_2222,1,0,1,CA+4,    3,0,4'h0);
    vecs[4]  = mk(1,0,0,'0,'0,          1,32'h3333_3333,1,0,1,CA+8,    3,0,4'h0);
    vecs[5]  = mk(1,0,0,'0,'0,          1,32'h4444_4444,1,0,1,CA+12,   3,0,4'h0);
    vecs[6]  = mk(0,0,0,'0,'0,          1,32'h5555_5555,0,0,0,'0,      0,0,4'h0);
    vecs[7]  = mk(0,1,1,LA,32'hDEAD_BEEF,0,'0,          0,0,0,'0,      0,0,4'h0);
    vecs[8]  = mk(0,1,1,LA,32'hDEAD_BEEF,0,'0,          0,0,1,LA,      0,1,4'hF);
    vecs[9]  = mk(0,1,1,LA,32'hDEAD_BEEF,1,'0,          0,1,1,LA,      0,1,4'hF);
    vecs[10] = mk(0,0,0,'0,'0,          0,'0,           0,0,0,'0,      0,0,4'h0);
    vecs[11] = mk(0,1,0,LR,'0,          0,'0,           0,0,0,'0,      0,0,4'h0);
    vecs[12] = mk(0,1,0,LR,'0,          1,32'hCAFE_F00D,0,1,1,LR,      0,0,4'hF);
    vecs[13] = mk(0,0,0,'0,'0,          0,'0,           0,0,0,'0,      0,0,4'h0);

    doReset();
    @(negedge clock);
    checkOutput("reset m_valid", 32'(mem_bus.m_valid), 32'd0);
    checkOutput("reset m_addr",  mem_bus.m_addr, 32'd0);
    checkOutput("reset m_len",   32'(mem_bus.m_len), 32'd0);
    checkOutput("reset m_wen",   32'(mem_bus.m_wen), 32'd0);
    checkOutput("reset m_wmask", 32'(mem_bus.m_wmask), 32'd0);
    checkOutput("reset m_wdata", mem_bus.m_wdata, 32'd0);
    checkOutput("reset m_burst", 32'(mem_bus.m_burst), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clock);
      #1 applyStimulus(vecs[i]);
      @(negedge clock);
      checkOutput($sformatf("v%0d c_ready", i), 32'(c_ready), 32'(vecs[i].e_crdy));
      checkOutput($sformatf("v%0d l_ready", i), 32'(l_ready), 32'(vecs[i].e_lrdy));
      checkOutput($sformatf("v%0d m_valid", i), 32'(mem_bus.m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        checkOutput($sformatf("v%0d m_addr", i),  mem_bus.m_addr, vecs[i].e_addr);
        checkOutput($sformatf("v%0d m_len", i),   32'(mem_bus.m_len), 32'(vecs[i].e_len));
        checkOutput($sformatf("v%0d m_wen", i),   32'(mem_bus.m_wen), 32'(vecs[i].e_wen));
        checkOutput($sformatf("v%0d m_wmask", i), 32'(mem_bus.m_wmask), 32'(vecs[i].e_wmask));
        if (vecs[i].e_wen)
          checkOutput($sformatf("v%0d m_wdata", i), mem_bus.m_wdata, vecs[i].lwdata);
      end
      if (vecs[i].e_crdy)
        checkOutput($sformatf("v%0d c_data", i), c_data, vecs[i].rdata);
      if (vecs[i].e_lrdy && !vecs[i].lw)
        checkOutput($sformatf("v%0d l_rdata", i), l_rdata, vecs[i].rdata);
    end

    // Both requesters held right after reset: cache first, then C,L,C,L
    // with exactly one IDLE cycle between consecutive grants.
    doReset();
    c_valid = 1'b1; c_addr = CA2; c_len = 8'd1; c_burst = 1'b0;
    l_valid = 1'b1; l_wen = 1'b0; l_addr = LA2; l_wmask = 4'hF;
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h1234_5678;
    grants = 0; idle_between = 0; crdy_cnt = 0; lrdy_cnt = 0; prev_mv = 1'b0;
    for (int cyc = 0; cyc < 30 && grants < 4; cyc++) begin
      @(negedge clock);
      if (mem_bus.m_valid && !prev_mv) begin
        checkOutput($sformatf("tie grant%0d addr", grants), mem_bus.m_addr,
                    (grants % 2 == 0) ? CA2 : LA2);
        grants++;
      end else if (!mem_bus.m_valid && grants > 0) begin
        idle_between++;
      end
      if (c_ready) crdy_cnt++;
      if (l_ready) lrdy_cnt++;
      prev_mv = mem_bus.m_valid;
      if (grants < 4) begin
        @(posedge clock);
        #1;
      end
    end
    checkOutput("tie grant count", 32'(grants), 32'd4);
    checkOutput("tie idle gaps", 32'(idle_between), 32'd3);
    checkOutput("tie c_ready pulses", 32'(crdy_cnt), 32'd4);
    checkOutput("tie l_ready pulses", 32'(lrdy_cnt), 32'd2);
    @(posedge clock);
    #1 c_valid = 1'b0; l_valid = 1'b0; mem_bus.m_ready = 1'b0;
    @(negedge clock);
    checkOutput("tie end m_valid", 32'(mem_bus.m_valid), 32'd0);

    // Burst refill; the cache drops c_valid after the first beat, which must
    // not cut the refill short.
    c_valid = 1'b1; c_addr = BA; c_len = 8'd3; c_burst = 1'b1;
    waitGrant("burst");
    for (int i = 0; i < 4; i++) begin
      mem_bus.m_ready = 1'b1;
      mem_bus.m_rdata = 32'hB000_0000 + 32'(i);
      #1;
      checkOutput($sformatf("burst b%0d m_valid", i), 32'(mem_bus.m_valid), 32'd1);
      checkOutput($sformatf("burst b%0d m_addr", i), mem_bus.m_addr, BA);
      checkOutput($sformatf("burst b%0d m_burst", i), 32'(mem_bus.m_burst), 32'd1);
      checkOutput($sformatf("burst b%0d c_ready", i), 32'(c_ready), 32'd1);
      checkOutput($sformatf("burst b%0d c_data", i), c_data, 32'hB000_0000 + 32'(i));
      @(posedge clock);
      #1;
      if (i == 0) c_valid = 1'b0;
      mem_bus.m_ready = 1'b0;
      @(negedge clock);
    end
    checkOutput("burst end m_valid", 32'(mem_bus.m_valid), 32'd0);

    // Reset during beat 2 of a 4-beat refill, then a fresh LSU read.
    c_valid = 1'b1; c_addr = 32'h3000_0100; c_len = 8'd3; c_burst = 1'b0;
    waitGrant("abort");
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h7777_0001;
    #1 checkOutput("abort beat1 c_ready", 32'(c_ready), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("abort reset-cycle c_ready", 32'(c_ready), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0; c_valid = 1'b0; mem_bus.m_ready = 1'b0;
    @(negedge clock);
    checkOutput("abort m_valid", 32'(mem_bus.m_valid), 32'd0);
    checkOutput("abort m_addr", mem_bus.m_addr, 32'd0);
    l_valid = 1'b1; l_wen = 1'b0; l_addr = 32'h8000_0040; l_wmask = 4'hF;
    waitGrant("post-abort lsu");
    checkOutput("post-abort m_addr", mem_bus.m_addr, 32'h8000_0040);
    checkOutput("post-abort m_wen", 32'(mem_bus.m_wen), 32'd0);
    checkOutput("post-abort m_len", 32'(mem_bus.m_len), 32'd0);
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h0BAD_CAFE;
    #1;
    checkOutput("post-abort l_ready", 32'(l_ready), 32'd1);
    checkOutput("post-abort l_rdata", l_rdata, 32'h0BAD_CAFE);
    checkOutput("post-abort c_ready", 32'(c_ready), 32'd0);
    @(posedge clock);
    #1 l_valid = 1'b0; mem_bus.m_ready = 1'b0;
    @(negedge clock);
    checkOutput("post-abort end m_valid", 32'(mem_bus.m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
